// File: rtl/bcd_hex6_display_if.sv
// Digit/control inputs and segment outputs between a BCD source and the
// six-digit seven-segment display driver.
interface bcd_hex6_display_if;
   logic       load;
   logic [3:0] digit_6;
   logic [3:0] digit_5;
   logic [3:0] digit_4;
   logic [3:0] digit_3;
   logic [3:0] digit_2;
   logic [3:0] digit_1;
   logic       lz_blank_en;
   logic [5:0] blink_mask;
   logic       lamp_test;
   logic [6:0] hex5;
   logic [6:0] hex4;
   logic [6:0] hex3;
   logic [6:0] hex2;
   logic [6:0] hex1;
   logic [6:0] hex0;
   logic       shown_valid;

   modport master (
      output load, digit_6, digit_5, digit_4, digit_3, digit_2, digit_1,
             lz_blank_en, blink_mask, lamp_test,
      input  hex5, hex4, hex3, hex2, hex1, hex0, shown_valid
   );

   modport slave (
      input  load, digit_6, digit_5, digit_4, digit_3, digit_2, digit_1,
             lz_blank_en, blink_mask, lamp_test,
      output hex5, hex4, hex3, hex2, hex1, hex0, shown_valid
   );
endinterface

// File: rtl/bcd_hex6_display.sv
// Six-digit BCD display driver: latches digits on load and drives registered,
// active-low segments with leading-zero blanking, blink and lamp test.
module bcd_hex6_display #(
   parameter int unsigned BLINK_DIV = 25000000,
   parameter int unsigned CNT_W     = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_hex6_display_if.slave bus
);

   localparam logic [6:0]       SEG_OFF  = 7'b1111111;
   localparam logic [6:0]       SEG_ALL  = 7'b0000000;
   localparam logic [6:0]       SEG_DASH = 7'b0111111;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic [6:0] encode(input logic [3:0] v);
      case (v)
         4'd0:    encode = 7'b1000000;
         4'd1:    encode = 7'b1111001;
         4'd2:    encode = 7'b0100100;
         4'd3:    encode = 7'b0110000;
         4'd4:    encode = 7'b0011001;
         4'd5:    encode = 7'b0010010;
         4'd6:    encode = 7'b0000010;
         4'd7:    encode = 7'b1111000;
         4'd8:    encode = 7'b0000000;
         4'd9:    encode = 7'b0010000;
         default: encode = SEG_DASH;
      endcase
   endfunction

   logic [5:0][3:0] digits_in;
   logic [5:0][3:0] digits_q, digits_d;
   logic            shown_valid_q, shown_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;
   logic [5:0][6:0] hex_q, hex_d;

   assign digits_in = {bus.digit_6, bus.digit_5, bus.digit_4,
                       bus.digit_3, bus.digit_2, bus.digit_1};

   always_comb begin
      digits_d      = bus.load ? digits_in : digits_q;
      shown_valid_d = shown_valid_q | bus.load;
   end

   // Idle mask parks the prescaler so a newly blinking digit starts visible.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (bus.blink_mask == 6'd0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      logic leading;
      hex_d   = '0;
      leading = 1'b1;
      for (int k = 5; k >= 0; k--) begin
         leading = leading && (digits_q[k] == 4'd0);
         if (bus.lamp_test)
            hex_d[k] = SEG_ALL;
         else if (!shown_valid_q)
            hex_d[k] = SEG_OFF;
         else if (bus.lz_blank_en && leading && (k != 0))
            hex_d[k] = SEG_OFF;
         else if (phase_q && bus.blink_mask[k])
            hex_d[k] = SEG_OFF;
         else
            hex_d[k] = encode(digits_q[k]);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their _d values from the same pre-edge state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q      <= '0;
         shown_valid_q <= 1'b0;
         cnt_q         <= '0;
         phase_q       <= 1'b0;
         hex_q         <= {6{SEG_OFF}};
      end else begin
         digits_q      <= digits_d;
         shown_valid_q <= shown_valid_d;
         cnt_q         <= cnt_d;
         phase_q       <= phase_d;
         hex_q         <= hex_d;
      end
   end

   assign bus.hex5        = hex_q[5];
   assign bus.hex4        = hex_q[4];
   assign bus.hex3        = hex_q[3];
   assign bus.hex2        = hex_q[2];
   assign bus.hex1        = hex_q[1];
   assign bus.hex0        = hex_q[0];
   assign bus.shown_valid = shown_valid_q;

endmodule

// File: tb/tb_bcd_hex6_display.sv
// Directed bench for bcd_hex6_display: vector table plus blink, hold and
// asynchronous-reset sequences, run with a short blink period.
module tb_bcd_hex6_display;

   localparam logic [6:0] S0   = 7'b1000000;
   localparam logic [6:0] S1   = 7'b1111001;
   localparam logic [6:0] S2   = 7'b0100100;
   localparam logic [6:0] S3   = 7'b0110000;
   localparam logic [6:0] S4   = 7'b0011001;
   localparam logic [6:0] S5   = 7'b0010010;
   localparam logic [6:0] S6   = 7'b0000010;
   localparam logic [6:0] S7   = 7'b1111000;
   localparam logic [6:0] S9   = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] OFF  = 7'b1111111;
   localparam logic [6:0] ON   = 7'b0000000;

   typedef struct {
      string            name;
      logic [23:0]      digits;  // top nibble is digit_6
      logic             lz;
      logic             lamp;
      logic [5:0][6:0]  hex;     // index k is HEXk
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   bcd_hex6_display_if bus ();

   bcd_hex6_display #(.BLINK_DIV(4), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [41:0] hex_all();
      return {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   task automatic set_digits(input logic [23:0] d);
      {bus.digit_6, bus.digit_5, bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1} = d;
   endtask

   // Drive at a falling edge, latch on the next rising edge, sample one edge later.
   task automatic load_digits(input logic [23:0] d);
      set_digits(d);
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      @(negedge clk);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{"lz_on_001207",  24'h001207, 1'b1, 1'b0, {OFF, OFF, S1, S2, S0, S7}};
      vecs[1] = '{"lz_off_001207", 24'h001207, 1'b0, 1'b0, {S0, S0, S1, S2, S0, S7}};
      vecs[2] = '{"lz_all_zero",   24'h000000, 1'b1, 1'b0, {OFF, OFF, OFF, OFF, OFF, S0}};
      vecs[3] = '{"dash_top",      24'hA00000, 1'b1, 1'b0, {DASH, S0, S0, S0, S0, S0}};
      vecs[4] = '{"dash_bottom",   24'h00000B, 1'b1, 1'b0, {OFF, OFF, OFF, OFF, OFF, DASH}};
      vecs[5] = '{"lz_inner_zero", 24'h003000, 1'b1, 1'b0, {OFF, OFF, S3, S0, S0, S0}};
      vecs[6] = '{"lamp_test",     24'h003000, 1'b1, 1'b1, {6{ON}}};
      vecs[7] = '{"plain_123456",  24'h123456, 1'b0, 1'b0, {S1, S2, S3, S4, S5, S6}};

      rst_n           = 1'b0;
      bus.load        = 1'b0;
      bus.lz_blank_en = 1'b0;
      bus.blink_mask  = 6'd0;
      bus.lamp_test   = 1'b0;
      set_digits(24'h000000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("reset_hex", hex_all(), {6{OFF}});
      check("reset_valid", {41'd0, bus.shown_valid}, 42'd0);
      bus.lamp_test = 1'b1;
      @(negedge clk);
      check("lamp_before_load", hex_all(), {6{ON}});
      bus.lamp_test = 1'b0;
      @(negedge clk);
      check("lamp_release_off", hex_all(), {6{OFF}});

      foreach (vecs[i]) begin
         bus.lz_blank_en = vecs[i].lz;
         bus.lamp_test   = vecs[i].lamp;
         load_digits(vecs[i].digits);
         check(vecs[i].name, hex_all(), vecs[i].hex);
         check("valid_after_load", {41'd0, bus.shown_valid}, 42'd1);
      end

      // Digits change without load: display holds, then follows one edge after the pulse.
      set_digits(24'h654321);
      repeat (3) @(negedge clk);
      check("hold_without_load", hex_all(), {S1, S2, S3, S4, S5, S6});
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      check("load_edge_not_yet", hex_all(), {S1, S2, S3, S4, S5, S6});
      @(negedge clk);
      check("load_pulse_update", hex_all(), {S6, S5, S4, S3, S2, S1});

      // Blink HEX0 with a 4-cycle half-period.
      load_digits(24'h999999);
      check("all_nines", hex_all(), {6{S9}});
      bus.blink_mask = 6'b000001;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         check($sformatf("blink_%0d", i), hex_all(),
               {{5{S9}}, (((i / 4) % 2) == 0) ? S9 : OFF});
      end
      bus.blink_mask = 6'd0;
      @(negedge clk);
      check("blink_clear", hex_all(), {6{S9}});
      @(negedge clk);
      bus.blink_mask = 6'b000001;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("blink_restart_%0d", i), hex_all(),
               {{5{S9}}, (i < 4) ? S9 : OFF});
      end

      // Asynchronous reset between edges while blinking.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_hex", hex_all(), {6{OFF}});
      check("async_reset_valid", {41'd0, bus.shown_valid}, 42'd0);
      @(negedge clk);
      rst_n          = 1'b1;
      bus.blink_mask = 6'd0;
      repeat (3) @(negedge clk);
      check("post_reset_off", hex_all(), {6{OFF}});
      check("post_reset_valid", {41'd0, bus.shown_valid}, 42'd0);
      load_digits(24'h123456);
      check("post_reset_load", hex_all(), {S1, S2, S3, S4, S5, S6});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
